// File: rtl/psum_requant_pack.sv
// psum_requant_pack: bias, round-shift, relu and saturate PE partial sums, then pack bytes into words.
module psum_requant_pack #(
  parameter int PSUM_WIDTH = 32,
  parameter int BIT_WIDTH  = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [PSUM_WIDTH-1:0] cfg_bias,
  input  logic [4:0]            cfg_shift,
  input  logic                  cfg_relu,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int LANES = OUT_WIDTH / BIT_WIDTH;
  localparam int LW = $clog2(LANES);
  localparam logic signed [PSUM_WIDTH+1:0] MAXV = (PSUM_WIDTH+2)'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic signed [PSUM_WIDTH+1:0] MINV = -MAXV - 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [LEN_WIDTH-1:0] len_q, acc_cnt;
  logic [PSUM_WIDTH-1:0] bias_q;
  logic [4:0] shift_q;
  logic relu_q, s1_valid, s1_last, s2_valid, s2_last, advance, xfer;
  logic [PSUM_WIDTH:0] s1_sum;
  logic [BIT_WIDTH-1:0] s2_byte, sat;
  logic [LW-1:0] lane_idx, idx;
  logic [OUT_WIDTH-1:0] next_word;
  logic signed [PSUM_WIDTH+1:0] sx, rnd, r, rr;
  assign advance = !out_valid || out_ready;
  assign in_ready = state == RUN && acc_cnt < len_q && advance;
  assign xfer = in_valid && in_ready;
  assign busy = state == RUN;
  // a handshaking word is emptied, so a lane written in that same cycle starts the next word
  always_comb begin
    sx = {s1_sum[PSUM_WIDTH], s1_sum};
    rnd = shift_q == 5'd0 ? '0 : (PSUM_WIDTH+2)'(1) << (shift_q - 5'd1);
    r = (sx + rnd) >>> shift_q;
    rr = relu_q && r < 0 ? '0 : r;
    sat = rr > MAXV ? MAXV[BIT_WIDTH-1:0] : rr < MINV ? MINV[BIT_WIDTH-1:0] : rr[BIT_WIDTH-1:0];
    idx = out_valid ? '0 : lane_idx;
    next_word = out_valid ? '0 : out_data;
    next_word[idx*BIT_WIDTH +: BIT_WIDTH] = s2_byte;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      bias_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      acc_cnt <= '0;
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_sum <= '0;
      s2_valid <= 1'b0;
      s2_last <= 1'b0;
      s2_byte <= '0;
      lane_idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && cfg_start) begin
        len_q <= cfg_len;
        bias_q <= cfg_bias;
        shift_q <= cfg_shift;
        relu_q <= cfg_relu;
        acc_cnt <= '0;
        if (cfg_len == '0) done <= 1'b1;
        else state <= RUN;
      end
      if (xfer) acc_cnt <= acc_cnt + 1'b1;
      if (advance) begin
        s1_valid <= xfer;
        s1_sum <= {in_psum[PSUM_WIDTH-1], in_psum} + {bias_q[PSUM_WIDTH-1], bias_q};
        s1_last <= acc_cnt == len_q - 1'b1;
        s2_valid <= s1_valid;
        s2_byte <= sat;
        s2_last <= s1_last;
        if (s2_valid) begin
          out_data <= next_word;
          lane_idx <= idx + 1'b1;
          out_valid <= idx == LW'(LANES - 1) || s2_last;
          out_last <= s2_last;
        end else if (out_valid) begin
          out_data <= '0;
          lane_idx <= '0;
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end
        if (out_valid && out_last) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_psum_requant_pack.sv
// tb_psum_requant_pack: directed scenarios with hand-computed packed words.
module tb_psum_requant_pack;
  logic clk = 1'b0;
  logic rst_n, cfg_start, cfg_relu, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [15:0] cfg_len;
  logic [31:0] cfg_bias, in_psum, out_data;
  logic [4:0] cfg_shift;
  int errors = 0, checks = 0, done_cnt = 0, done_busy = 0;
  int ps[16];
  logic [31:0] wq[$];
  logic lq[$];
  psum_requant_pack dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      wq.push_back(out_data);
      lq.push_back(out_last);
    end
    if (rst_n && done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
  end
  task automatic start_run(input int len, input int bias, input int sh, input bit rl);
    @(negedge clk);
    cfg_len = 16'(len);
    cfg_bias = bias;
    cfg_shift = 5'(sh);
    cfg_relu = rl;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask
  task automatic feed(input int n, output bit to);
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_psum = ps[i];
      #1;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 300) to = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_done(input int d0, output bit to);
    int t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    to = done_cnt == d0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    int n0 = wq.size(), d0 = done_cnt;
    bit t1, t2;
    ps[0] = 1; ps[1] = -1; ps[2] = 127; ps[3] = 200;
    start_run(4, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run got=%b exp=1", busy); end
    feed(4, t1);
    wait_done(d0, t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL basic_timeout got=%b%b exp=00", t1, t2); end
    checks++; if (wq.size() - n0 != 1) begin errors++; $display("FAIL basic_words got=%0d exp=1", wq.size() - n0); end
    checks++; if (wq[n0] !== 32'h7F7FFF01) begin errors++; $display("FAIL basic_word got=%h exp=7f7fff01", wq[n0]); end
    checks++; if (lq[n0] !== 1'b1) begin errors++; $display("FAIL basic_last got=%b exp=1", lq[n0]); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask
  task automatic test_round;
    int n0 = wq.size(), d0 = done_cnt;
    bit t1, t2;
    ps[0] = 6; ps[1] = -6; ps[2] = 5;
    start_run(3, 0, 2, 0);
    feed(3, t1);
    wait_done(d0, t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL round_timeout got=%b%b exp=00", t1, t2); end
    checks++; if (wq[n0] !== 32'h0001FF02) begin errors++; $display("FAIL round_word got=%h exp=0001ff02", wq[n0]); end
    checks++; if (lq[n0] !== 1'b1) begin errors++; $display("FAIL round_last got=%b exp=1", lq[n0]); end
  endtask
  task automatic test_relu;
    int n0 = wq.size(), d0 = done_cnt;
    bit t1, t2;
    ps[0] = -40; ps[1] = 310;
    start_run(2, -10, 0, 1);
    feed(2, t1);
    wait_done(d0, t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL relu_timeout got=%b%b exp=00", t1, t2); end
    checks++; if (wq[n0] !== 32'h00007F00) begin errors++; $display("FAIL relu_word got=%h exp=00007f00", wq[n0]); end
  endtask
  task automatic test_multi;
    int n0 = wq.size(), d0 = done_cnt;
    bit t1, t2;
    for (int i = 0; i < 6; i++) ps[i] = i + 1;
    start_run(6, 0, 0, 0);
    fork
      feed(6, t1);
      begin
        repeat (2) @(negedge clk);
        cfg_len = 16'd1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
      end
    join
    wait_done(d0, t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL multi_timeout got=%b%b exp=00", t1, t2); end
    checks++; if (wq.size() - n0 != 2) begin errors++; $display("FAIL multi_words got=%0d exp=2", wq.size() - n0); end
    checks++; if (wq[n0] !== 32'h04030201 || lq[n0] !== 1'b0) begin errors++; $display("FAIL multi_word0 got=%h/%b exp=04030201/0", wq[n0], lq[n0]); end
    checks++; if (wq[n0+1] !== 32'h00000605 || lq[n0+1] !== 1'b1) begin errors++; $display("FAIL multi_word1 got=%h/%b exp=00000605/1", wq[n0+1], lq[n0+1]); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL multi_done_count got=%0d exp=1", done_cnt - d0); end
  endtask
  task automatic test_stall;
    int n0 = wq.size(), d0 = done_cnt, bad = 0, t = 0;
    bit t1, t2;
    for (int i = 0; i < 8; i++) ps[i] = i + 1;
    out_ready = 1'b0;
    start_run(8, 0, 0, 0);
    fork
      feed(8, t1);
      begin
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (out_data !== 32'h04030201 || !out_valid || out_last || in_ready) bad++;
        end
        out_ready = 1'b1;
      end
    join
    wait_done(d0, t2);
    checks++; if (t1 || t2 || t >= 100) begin errors++; $display("FAIL stall_timeout got=%b%b%0d exp=00 under 100", t1, t2, t); end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    checks++; if (wq.size() - n0 != 2) begin errors++; $display("FAIL stall_words got=%0d exp=2", wq.size() - n0); end
    checks++; if (wq[n0] !== 32'h04030201) begin errors++; $display("FAIL stall_word0 got=%h exp=04030201", wq[n0]); end
    checks++; if (wq[n0+1] !== 32'h08070605 || lq[n0+1] !== 1'b1) begin errors++; $display("FAIL stall_word1 got=%h/%b exp=08070605/1", wq[n0+1], lq[n0+1]); end
  endtask
  task automatic test_reset_midrun;
    int n0 = wq.size(), d0;
    bit t1, t2;
    for (int i = 0; i < 4; i++) ps[i] = i + 1;
    start_run(4, 0, 0, 0);
    feed(2, t1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got=busy%b ov%b od%h ol%b dn%b exp=all 0", busy, out_valid, out_data, out_last, done); end
    in_valid = 1'b1;
    in_psum = 32'd9;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    checks++; if (wq.size() != n0) begin errors++; $display("FAIL midrst_no_word got=%0d exp=0", wq.size() - n0); end
    d0 = done_cnt;
    ps[0] = 5;
    start_run(1, 0, 0, 0);
    feed(1, t2);
    wait_done(d0, t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL midrst_timeout got=%b%b exp=00", t1, t2); end
    checks++; if (wq[n0] !== 32'h00000005 || lq[n0] !== 1'b1) begin errors++; $display("FAIL midrst_word got=%h/%b exp=00000005/1", wq[n0], lq[n0]); end
  endtask
  task automatic test_len0;
    int n0 = wq.size(), d0 = done_cnt;
    start_run(0, 0, 0, 0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done got=%b busy=%b exp=1/0", done, busy); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (wq.size() != n0 || busy !== 1'b0) begin errors++; $display("FAIL len0_idle got=%0d words busy=%b exp=0/0", wq.size() - n0, busy); end
  endtask
  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_len = '0; cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
    test_reset;
    test_basic;
    test_round;
    test_relu;
    test_multi;
    test_stall;
    test_reset_midrun;
    test_len0;
    checks++; if (done_busy != 0) begin errors++; $display("FAIL done_with_busy got=%0d exp=0", done_busy); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_requant_pack.md
PSUM_REQUANT_PACK -- requirements
Module: psum_requant_pack

Interface
REQ-001 SHALL have parameters: PSUM_WIDTH, 32, signed PE partial-sum width; BIT_WIDTH, 8, requantized activation width; OUT_WIDTH, 32, packed output word width (OUT_WIDTH/BIT_WIDTH = 4 lanes); LEN_WIDTH, 16, element-count width.
REQ-002 SHALL have one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 cfg_start  input  1  one-cycle pulse; latches cfg_* and starts a run.
REQ-006 cfg_len  input  LEN_WIDTH  psums in the run.
REQ-007 cfg_bias  input  PSUM_WIDTH  signed bias added to every psum.
REQ-008 cfg_shift  input  5  arithmetic right-shift amount, 0..31.
REQ-009 cfg_relu  input  1  1 = clamp negatives to 0.
REQ-010 in_valid / in_ready  input / output  1 / 1  psum stream handshake.
REQ-011 in_psum  input  PSUM_WIDTH  signed psum from PE array.
REQ-012 out_valid / out_ready  output / input  1 / 1  packed-word handshake.
REQ-013 out_data  output  OUT_WIDTH  packed bytes; element k of a word in bits [8k+7:8k].
REQ-014 out_last  output  1  marks the final word of a run.
REQ-015 busy  output  1  high while state != IDLE.
REQ-016 done  output  1  one-cycle pulse when a run completes.

Function
REQ-017 SHALL implement states IDLE, RUN; IDLE->RUN on cfg_start; RUN->IDLE on handshake of the out_last word; cfg_start outside IDLE SHALL be ignored.
REQ-018 cfg_start with cfg_len=0 SHALL stay in IDLE, produce no word, and pulse done on the following cycle.
REQ-019 advance = !out_valid || out_ready; stage registers and packer SHALL update only when advance is 1.
REQ-020 in_ready SHALL equal (state==RUN) && (accepted count < cfg_len) && advance; a transfer occurs when in_valid && in_ready.
REQ-021 Stage 1 SHALL register s = in_psum + cfg_bias in PSUM_WIDTH+1 signed bits (no overflow).
REQ-022 Stage 2 SHALL compute r = (s + 2^(shift-1)) >>> shift for shift>0, r = s for shift=0, in PSUM_WIDTH+2 bits; if cfg_relu and r<0 then r=0; then saturate to [-128,127].
REQ-023 Stage 2 output SHALL write into packer lane lane_idx (0..3), incrementing lane_idx; other lanes hold.
REQ-024 After lane 3 is written, or after the cfg_len-th element is written, out_valid SHALL assert on the next cycle with the word; unwritten lanes SHALL be 0; out_last SHALL be 1 only for the word containing element cfg_len.
REQ-025 Latency: psum accepted at edge t SHALL occupy its lane at edge t+2 when no stall occurs.
REQ-026 While out_valid && !out_ready, out_data, out_last, out_valid and all pipeline contents SHALL hold stable and no input SHALL be accepted.
REQ-027 After each word handshake lane_idx and packer SHALL clear to 0; full-rate throughput SHALL be one psum per cycle with out_ready held high.
REQ-028 done SHALL pulse in the cycle after the out_last handshake, with busy low in that same cycle.

Reset
REQ-029 On rst_n=0 at a clock edge: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, counters, lane_idx, stage valids cleared; any in-flight run SHALL be discarded.
REQ-030 After reset release the block SHALL require a new cfg_start before accepting psums.

Verification
REQ-031 bias=0, shift=0, relu=0, len=4, psums 1,-1,127,200 -> one word 0x7F7FFF01, out_last=1, done pulses once.
REQ-032 shift=2, bias=0, relu=0, len=3, psums 6,-6,5 -> word 0x0001FF02 (2,-1,1, lane 3 zero), out_last=1.
REQ-033 relu=1, bias=-10, shift=0, len=2, psums -40,310 -> word 0x00007F00.
REQ-034 len=6, psums 1..6 -> words 0x04030201 (out_last=0) then 0x00000605 (out_last=1).
REQ-035 len=8 streaming, out_ready low 10 cycles on first word -> out_data stable, in_ready low during stall, both words correct, no loss or duplication.
REQ-036 rst_n low after 2 of len=4 psums accepted -> all outputs at reset values, no word emitted; new run len=1 psum 5 -> word 0x00000005.
